id_stream_feeder: RTL and testbench

Upstream stage of the ID checker. Accepts one complete ID (NUM_SYM symbols, SYM_W bits each) per request through a valid/ready handshake. Streams the symbols to the checker as a contiguous burst of out_valid/out_id cycles, then waits, with a timeout, for the checker's single-cycle verdict. Returns the verdict to the requester and keeps saturating legal/illegal/timeout statistics.

---
 rtl/id_feed_pkg.sv | 30 +++
 rtl/id_feed_stats.sv | 61 ++++++
 rtl/id_stream_feeder.sv | 150 +++++++++++++++
 tb/tb_id_stream_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_feed_pkg.sv
`default_nettype none
// ============================================================================
// Module : id_feed_pkg
// Brief  : Shared types, default sizes and helpers for the ID stream feeder.
// Rev    : 1.0
// ============================================================================
package id_feed_pkg;

    localparam int unsigned DEF_SYM_W   = 6;
    localparam int unsigned DEF_NUM_SYM = 10;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam int unsigned DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Saturating increment on a 32-bit carrier; callers narrow the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result;
        result = (value >= max_value) ? value : value + 32'd1;
        return result;
    endfunction

endpackage : id_feed_pkg
`default_nettype wire

// File: rtl/id_feed_stats.sv
`default_nettype none
// ============================================================================
// Module : id_feed_stats
// Brief  : Saturating legal / illegal / timeout verdict counters.
// Rev    : 1.0
// ============================================================================
module id_feed_stats
    import id_feed_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_valid_i,
    input  logic             done_legal_i,
    input  logic             done_timeout_i,
    output logic [CNT_W-1:0] legal_cnt_o,
    output logic [CNT_W-1:0] illegal_cnt_o,
    output logic [CNT_W-1:0] timeout_cnt_o
);

    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic [CNT_W-1:0] legal_q,   legal_d;
    logic [CNT_W-1:0] illegal_q, illegal_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;

    // A timeout outranks the legal flag, which is always 0 alongside it anyway.
    always_comb begin
        legal_d   = legal_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        if (done_valid_i) begin
            if (done_timeout_i) begin
                timeout_d = CNT_W'(sat_inc(32'(timeout_q), CNT_MAX));
            end else if (done_legal_i) begin
                legal_d = CNT_W'(sat_inc(32'(legal_q), CNT_MAX));
            end else begin
                illegal_d = CNT_W'(sat_inc(32'(illegal_q), CNT_MAX));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            legal_q   <= '0;
            illegal_q <= '0;
            timeout_q <= '0;
        end else begin
            legal_q   <= legal_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign legal_cnt_o   = legal_q;
    assign illegal_cnt_o = illegal_q;
    assign timeout_cnt_o = timeout_q;

endmodule : id_feed_stats
`default_nettype wire

// File: rtl/id_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module : id_stream_feeder
// Brief  : Accepts a whole ID, bursts its symbols to the checker, waits for
//          the verdict with a timeout and reports it with statistics.
// Rev    : 1.0
// ============================================================================
module id_stream_feeder
    import id_feed_pkg::*;
#(
    parameter int unsigned SYM_W   = DEF_SYM_W,
    parameter int unsigned NUM_SYM = DEF_NUM_SYM,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [NUM_SYM*SYM_W-1:0] req_id,
    output logic                     req_ready,
    output logic                     out_valid,
    output logic [SYM_W-1:0]         out_id,
    input  logic                     chk_valid,
    input  logic                     chk_legal,
    output logic                     done_valid,
    output logic                     done_legal,
    output logic                     done_timeout,
    output logic [CNT_W-1:0]         legal_cnt,
    output logic [CNT_W-1:0]         illegal_cnt,
    output logic [CNT_W-1:0]         timeout_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_SYM + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    state_t                     state_q,        state_d;
    logic [NUM_SYM*SYM_W-1:0]   buf_q,          buf_d;
    logic [IDX_W-1:0]           idx_q,          idx_d;
    logic [TMR_W-1:0]           tmr_q,          tmr_d;
    logic                       out_valid_q,    out_valid_d;
    logic [SYM_W-1:0]           out_id_q,       out_id_d;
    logic                       done_valid_q,   done_valid_d;
    logic                       done_legal_q,   done_legal_d;
    logic                       done_timeout_q, done_timeout_d;

    // Symbol 0 leaves on the accept edge itself, so the burst starts the very
    // next cycle; the buffer then shifts down one symbol per send.
    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        idx_d          = idx_q;
        tmr_d          = tmr_q;
        out_valid_d    = 1'b0;
        out_id_d       = '0;
        done_valid_d   = 1'b0;
        done_legal_d   = 1'b0;
        done_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    buf_d       = req_id >> SYM_W;
                    out_valid_d = 1'b1;
                    out_id_d    = req_id[SYM_W-1:0];
                    idx_d       = IDX_W'(1);
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (idx_q == IDX_W'(NUM_SYM)) begin
                    idx_d   = '0;
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    out_valid_d = 1'b1;
                    out_id_d    = buf_q[SYM_W-1:0];
                    buf_d       = buf_q >> SYM_W;
                    idx_d       = idx_q + IDX_W'(1);
                end
            end
            S_WAIT: begin
                tmr_d = tmr_q + TMR_W'(1);
                // A verdict on the last allowed cycle still beats the timeout.
                if (chk_valid) begin
                    done_valid_d = 1'b1;
                    done_legal_d = chk_legal;
                    tmr_d        = '0;
                    state_d      = S_DONE;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    done_valid_d   = 1'b1;
                    done_timeout_d = 1'b1;
                    tmr_d          = '0;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            buf_q          <= '0;
            idx_q          <= '0;
            tmr_q          <= '0;
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            done_valid_q   <= 1'b0;
            done_legal_q   <= 1'b0;
            done_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            idx_q          <= idx_d;
            tmr_q          <= tmr_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            done_valid_q   <= done_valid_d;
            done_legal_q   <= done_legal_d;
            done_timeout_q <= done_timeout_d;
        end
    end

    id_feed_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk            (clk),
        .rst_n          (rst_n),
        .done_valid_i   (done_valid_q),
        .done_legal_i   (done_legal_q),
        .done_timeout_i (done_timeout_q),
        .legal_cnt_o    (legal_cnt),
        .illegal_cnt_o  (illegal_cnt),
        .timeout_cnt_o  (timeout_cnt)
    );

    assign req_ready    = (state_q == S_IDLE);
    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign done_valid   = done_valid_q;
    assign done_legal   = done_legal_q;
    assign done_timeout = done_timeout_q;

endmodule : id_stream_feeder
`default_nettype wire

// File: tb/tb_id_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_id_stream_feeder
// Brief  : Self-checking bench: vector table, corner sequences, random IDs.
// Rev    : 1.0
// ============================================================================
module tb_id_stream_feeder;

    localparam int SYM_W   = 6;
    localparam int NUM_SYM = 10;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int IDW     = NUM_SYM * SYM_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic [IDW-1:0]   req_id = '0;
    logic             req_ready;
    logic             out_valid;
    logic [SYM_W-1:0] out_id;
    logic             chk_valid = 1'b0;
    logic             chk_legal = 1'b0;
    logic             done_valid;
    logic             done_legal;
    logic             done_timeout;
    logic [CNT_W-1:0] legal_cnt;
    logic [CNT_W-1:0] illegal_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    id_stream_feeder #(
        .SYM_W   (SYM_W),
        .NUM_SYM (NUM_SYM),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_id       (req_id),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_id       (out_id),
        .chk_valid    (chk_valid),
        .chk_legal    (chk_legal),
        .done_valid   (done_valid),
        .done_legal   (done_legal),
        .done_timeout (done_timeout),
        .legal_cnt    (legal_cnt),
        .illegal_cnt  (illegal_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int m_legal = 0, m_illegal = 0, m_timeout = 0;
    int last_accept = 0;

    typedef struct {
        logic [IDW-1:0] id;
        int             delay;
        logic           legal;
        bit             exp_legal;
        bit             exp_to;
        int             exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Outcome derived from the WAIT-cycle index at which the checker answers.
    function automatic void expect_of(input int delay, input logic legal,
                                      output bit el, output bit et, output int lat);
        if (delay < TIMEOUT) begin
            el = legal; et = 1'b0; lat = delay + 1;
        end else begin
            el = 1'b0;  et = 1'b1; lat = TIMEOUT;
        end
    endfunction

    function automatic logic [IDW-1:0] rand_id();
        logic [IDW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_SYM; k++) v[k*SYM_W +: SYM_W] = SYM_W'($urandom_range(0, (1 << SYM_W) - 1));
        return v;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_legal_cnt"},   64'(legal_cnt),   64'(m_legal));
        check({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'(m_illegal));
        check({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'(m_timeout));
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic run_id(input logic [IDW-1:0] id, input int delay, input logic legal,
                          input bit hold_req, input bit noise, input int exp_spacing,
                          input bit exp_legal, input bit exp_to, input int exp_lat);
        int lat;
        req_valid = 1'b1;
        req_id    = id;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        step();
        if (exp_spacing > 0) check("accept_spacing", 64'(cyc - last_accept), 64'(exp_spacing));
        last_accept = cyc;
        req_valid = hold_req;
        req_id    = rand_id();
        for (int k = 0; k < NUM_SYM; k++) begin
            check("burst_valid", 64'(out_valid), 64'd1);
            check("burst_sym",   64'(out_id),    64'(id[k*SYM_W +: SYM_W]));
            check("burst_ready", 64'(req_ready), 64'd0);
            check("burst_done",  64'(done_valid), 64'd0);
            chk_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            chk_legal = 1'($urandom_range(0, 1));
            step();
        end
        chk_valid = 1'b0;
        lat = 0;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            check("wait_out_valid", 64'(out_valid), 64'd0);
            check("wait_out_id",    64'(out_id),    64'd0);
            if (done_valid === 1'b1) break;
            chk_valid = (c == delay);
            chk_legal = (c == delay) ? legal : 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        chk_valid = 1'b0;
        check("verdict_latency", 64'(lat), 64'(exp_lat));
        check("done_valid",   64'(done_valid),   64'd1);
        check("done_legal",   64'(done_legal),   64'(exp_legal));
        check("done_timeout", 64'(done_timeout), 64'(exp_to));
        check("done_ready",   64'(req_ready),    64'd0);
        if (exp_to)         m_timeout = sat(m_timeout);
        else if (exp_legal) m_legal   = sat(m_legal);
        else                m_illegal = sat(m_illegal);
        chk_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        chk_valid = 1'b0;
        check("post_done_valid",   64'(done_valid),   64'd0);
        check("post_done_legal",   64'(done_legal),   64'd0);
        check("post_done_timeout", 64'(done_timeout), 64'd0);
        check("post_ready",        64'(req_ready),    64'd1);
        check_counters("post");
        if (!hold_req) req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        chk_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_legal = 0; m_illegal = 0; m_timeout = 0;
        step();
    endtask

    initial begin
        logic [IDW-1:0] seq_id;
        bit el, et;
        int lat, d;
        logic lg;

        seq_id = '0;
        for (int k = 0; k < NUM_SYM; k++) seq_id[k*SYM_W +: SYM_W] = SYM_W'(k + 1);
        vecs[0] = '{seq_id,     1,  1'b1, 1'b1, 1'b0, 2};
        vecs[1] = '{rand_id(),  0,  1'b0, 1'b0, 1'b0, 1};
        vecs[2] = '{rand_id(),  99, 1'b1, 1'b0, 1'b1, 16};
        vecs[3] = '{rand_id(),  15, 1'b1, 1'b1, 1'b0, 16};
        vecs[4] = '{rand_id(),  15, 1'b0, 1'b0, 1'b0, 16};
        vecs[5] = '{rand_id(),  16, 1'b1, 1'b0, 1'b1, 16};

        #2;
        check("rst_ready",     64'(req_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid),  64'd0);
        check("rst_out_id",    64'(out_id),     64'd0);
        check("rst_done",      64'(done_valid), 64'd0);
        do_reset();
        check_counters("rst");

        for (int i = 0; i < 6; i++)
            run_id(vecs[i].id, vecs[i].delay, vecs[i].legal, 1'b0, (i > 1), 0,
                   vecs[i].exp_legal, vecs[i].exp_to, vecs[i].exp_lat);

        // Verdict strobes while idle must be ignored.
        for (int i = 0; i < 4; i++) begin
            chk_valid = 1'b1;
            chk_legal = 1'($urandom_range(0, 1));
            step();
            check("idle_noise_done",  64'(done_valid), 64'd0);
            check("idle_noise_ready", 64'(req_ready),  64'd1);
        end
        chk_valid = 1'b0;
        check_counters("idle_noise");

        // Back-to-back with req_valid held throughout.
        for (int i = 0; i < 3; i++)
            run_id(rand_id(), 0, 1'b1, 1'b1, 1'b0, (i == 0) ? 0 : NUM_SYM + 3, 1'b1, 1'b0, 1);
        req_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            d  = $urandom_range(0, TIMEOUT + 2);
            lg = 1'($urandom_range(0, 1));
            expect_of(d, lg, el, et, lat);
            run_id(rand_id(), d, lg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, el, et, lat);
        end
        req_valid = 1'b0;

        for (int i = 0; i < 300; i++) run_id(rand_id(), 0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1);
        check("legal_saturated", 64'(legal_cnt), 64'(CNT_MAX));

        // Reset asserted during the fifth symbol of a burst.
        seq_id = rand_id();
        req_valid = 1'b1;
        req_id    = seq_id;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("mid_burst_valid", 64'(out_valid), 64'd1);
        check("mid_burst_sym",   64'(out_id),    64'(seq_id[4*SYM_W +: SYM_W]));
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_legal_cnt", 64'(legal_cnt), 64'd0);
        check("async_rst_ready",     64'(req_ready), 64'd1);
        step();
        rst_n = 1'b1;
        m_legal = 0; m_illegal = 0; m_timeout = 0;
        step();
        check("after_rst_ready", 64'(req_ready), 64'd1);
        check_counters("after_rst");
        run_id(rand_id(), 3, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_id_stream_feeder
`default_nettype wire
